// File: rtl/core_conversion_controller.sv
// core_conversion_controller
// Sequences the RGB-to-grayscale conversion: reads R,G,B of each pixel from
// the input region, hands the triple to the converter, and writes the gray
// result back into all three channels of the processed region.
module core_conversion_controller #(
    parameter int unsigned              ADDR_WIDTH               = 32,
    parameter int unsigned              IMEM_WIDTH               = 8,
    parameter logic [ADDR_WIDTH-1:0]    IMEM_BASE_ADDR           = '0,
    parameter int unsigned              IMEM_SIZE                = 122880,
    parameter logic [ADDR_WIDTH-1:0]    PROCESSED_IMEM_BASE_ADDR = IMEM_BASE_ADDR + ADDR_WIDTH'(IMEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  resume,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pixel_count,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [IMEM_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [IMEM_WIDTH-1:0] mem_wr_data,
    output logic                  cvt_in_valid,
    input  logic                  cvt_in_ready,
    output logic [IMEM_WIDTH-1:0] cvt_r,
    output logic [IMEM_WIDTH-1:0] cvt_g,
    output logic [IMEM_WIDTH-1:0] cvt_b,
    input  logic                  cvt_out_valid,
    input  logic [IMEM_WIDTH-1:0] cvt_out_data,
    output logic [2:0]            state,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] pixels_done,
    output logic                  cfg_error
);

    localparam logic [ADDR_WIDTH-1:0] MAX_PIXELS = ADDR_WIDTH'(IMEM_SIZE / 3);
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_WAIT  = 3'd1,
        ST_PROC  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ABORT = 3'd4,
        ST_DONE  = 3'd5
    } core_states_t;

    // Per-pixel sub-steps inside processing
    typedef enum logic [3:0] {
        SUB_RD_R, SUB_RD_G, SUB_RD_B, SUB_CAP, SUB_CVT,
        SUB_WAIT_RES, SUB_WR_R, SUB_WR_G, SUB_WR_B
    } sub_t;

    core_states_t          state_reg, state_next;
    sub_t                  sub_reg, sub_next;
    logic [ADDR_WIDTH-1:0] count_reg, count_next;
    logic [ADDR_WIDTH-1:0] pixels_done_reg, pixels_done_next;
    // Next address to be issued on each port (running counters, no multiply)
    logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic                  rd_en_reg, rd_en_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic                  wr_en_reg, wr_en_next;
    logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [IMEM_WIDTH-1:0] wr_data_reg, wr_data_next;
    logic                  cvt_valid_reg, cvt_valid_next;
    logic [IMEM_WIDTH-1:0] r_reg, r_next, g_reg, g_next, b_reg, b_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  cfg_error_reg, cfg_error_next;

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_RESET;
            sub_reg         <= SUB_RD_R;
            count_reg       <= '0;
            pixels_done_reg <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            rd_en_reg       <= 1'b0;
            rd_addr_reg     <= '0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            cvt_valid_reg   <= 1'b0;
            r_reg           <= '0;
            g_reg           <= '0;
            b_reg           <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            cfg_error_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sub_reg         <= sub_next;
            count_reg       <= count_next;
            pixels_done_reg <= pixels_done_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_en_reg       <= rd_en_next;
            rd_addr_reg     <= rd_addr_next;
            wr_en_reg       <= wr_en_next;
            wr_addr_reg     <= wr_addr_next;
            wr_data_reg     <= wr_data_next;
            cvt_valid_reg   <= cvt_valid_next;
            r_reg           <= r_next;
            g_reg           <= g_next;
            b_reg           <= b_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            cfg_error_reg   <= cfg_error_next;
        end
    end

    // Next-state and next-output logic; strobes default low, everything else holds
    always_comb begin
        state_next       = state_reg;
        sub_next         = sub_reg;
        count_next       = count_reg;
        pixels_done_next = pixels_done_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_en_next       = 1'b0;
        rd_addr_next     = rd_addr_reg;
        wr_en_next       = 1'b0;
        wr_addr_next     = wr_addr_reg;
        wr_data_next     = wr_data_reg;
        cvt_valid_next   = 1'b0;
        r_next           = r_reg;
        g_next           = g_reg;
        b_next           = b_reg;
        cfg_error_next   = 1'b0;

        case (state_reg)
            ST_RESET: state_next = ST_WAIT;

            ST_WAIT, ST_DONE: begin
                if (start) begin
                    if (pixel_count != '0 && pixel_count <= MAX_PIXELS) begin
                        state_next       = ST_PROC;
                        sub_next         = SUB_RD_R;
                        count_next       = pixel_count;
                        pixels_done_next = '0;
                        rd_en_next       = 1'b1;
                        rd_addr_next     = IMEM_BASE_ADDR;
                        rd_ptr_next      = IMEM_BASE_ADDR + ONE;
                        wr_ptr_next      = PROCESSED_IMEM_BASE_ADDR;
                    end else begin
                        cfg_error_next = 1'b1;
                    end
                end
            end

            ST_PROC: begin
                if (abort) begin
                    state_next = ST_ABORT;
                end else begin
                    case (sub_reg)
                        SUB_RD_R: begin
                            sub_next     = SUB_RD_G;
                            rd_en_next   = 1'b1;
                            rd_addr_next = rd_ptr_reg;
                            rd_ptr_next  = rd_ptr_reg + ONE;
                        end
                        SUB_RD_G: begin
                            // read data lags its strobe by one cycle: this is R
                            r_next       = mem_rd_data;
                            sub_next     = SUB_RD_B;
                            rd_en_next   = 1'b1;
                            rd_addr_next = rd_ptr_reg;
                            rd_ptr_next  = rd_ptr_reg + ONE;
                        end
                        SUB_RD_B: begin
                            g_next   = mem_rd_data;
                            sub_next = SUB_CAP;
                        end
                        SUB_CAP: begin
                            b_next         = mem_rd_data;
                            sub_next       = SUB_CVT;
                            cvt_valid_next = 1'b1;
                        end
                        SUB_CVT: begin
                            if (cvt_in_ready) begin
                                sub_next = SUB_WAIT_RES;
                            end else begin
                                cvt_valid_next = 1'b1;
                            end
                        end
                        SUB_WAIT_RES: begin
                            if (cvt_out_valid) begin
                                sub_next     = SUB_WR_R;
                                wr_data_next = cvt_out_data;
                                wr_en_next   = 1'b1;
                                wr_addr_next = wr_ptr_reg;
                                wr_ptr_next  = wr_ptr_reg + ONE;
                            end
                        end
                        SUB_WR_R, SUB_WR_G: begin
                            sub_next     = (sub_reg == SUB_WR_R) ? SUB_WR_G : SUB_WR_B;
                            wr_en_next   = 1'b1;
                            wr_addr_next = wr_ptr_reg;
                            wr_ptr_next  = wr_ptr_reg + ONE;
                        end
                        SUB_WR_B: begin
                            pixels_done_next = pixels_done_reg + ONE;
                            if (pixels_done_reg + ONE == count_reg) begin
                                state_next = ST_DONE;
                            end else if (pause) begin
                                state_next = ST_PAUSE;
                                sub_next   = SUB_RD_R;
                            end else begin
                                sub_next     = SUB_RD_R;
                                rd_en_next   = 1'b1;
                                rd_addr_next = rd_ptr_reg;
                                rd_ptr_next  = rd_ptr_reg + ONE;
                            end
                        end
                        default: sub_next = SUB_RD_R;
                    endcase
                end
            end

            ST_PAUSE: begin
                if (abort) begin
                    state_next = ST_ABORT;
                end else if (resume) begin
                    state_next   = ST_PROC;
                    sub_next     = SUB_RD_R;
                    rd_en_next   = 1'b1;
                    rd_addr_next = rd_ptr_reg;
                    rd_ptr_next  = rd_ptr_reg + ONE;
                end
            end

            ST_ABORT: state_next = ST_WAIT;

            default: state_next = ST_WAIT;
        endcase

        busy_next = (state_next == ST_PROC) || (state_next == ST_PAUSE);
        done_next = (state_next == ST_DONE);
    end

    assign state        = state_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign pixels_done  = pixels_done_reg;
    assign cfg_error    = cfg_error_reg;
    assign mem_rd_en    = rd_en_reg;
    assign mem_rd_addr  = rd_addr_reg;
    assign mem_wr_en    = wr_en_reg;
    assign mem_wr_addr  = wr_addr_reg;
    assign mem_wr_data  = wr_data_reg;
    assign cvt_in_valid = cvt_valid_reg;
    assign cvt_r        = r_reg;
    assign cvt_g        = g_reg;
    assign cvt_b        = b_reg;

endmodule

// File: tb/tb_core_conversion_controller.sv
// Directed testbench for core_conversion_controller: memory with 1-cycle
// read latency, a converter answering 1 cycle after acceptance, and one task
// per scenario with inline checks against hand-computed values.
`timescale 1ns/1ps
module tb_core_conversion_controller;

    localparam int AW = 32;
    localparam int DW = 8;
    localparam logic [AW-1:0] OUT_BASE = 32'd122880;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, pause = 1'b0, resume = 1'b0, abort = 1'b0;
    logic [AW-1:0] pixel_count = '0;
    logic          mem_rd_en, mem_wr_en, cvt_in_valid, busy, done, cfg_error;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr, pixels_done;
    logic [DW-1:0] mem_rd_data = '0, mem_wr_data, cvt_r, cvt_g, cvt_b;
    logic          cvt_in_ready = 1'b1;
    logic          cvt_out_valid = 1'b0;
    logic [DW-1:0] cvt_out_data = '0;
    logic [2:0]    state;

    int n_checks = 0;
    int n_fail = 0;

    core_conversion_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .resume(resume),
        .abort(abort), .pixel_count(pixel_count),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .cvt_in_valid(cvt_in_valid), .cvt_in_ready(cvt_in_ready),
        .cvt_r(cvt_r), .cvt_g(cvt_g), .cvt_b(cvt_b),
        .cvt_out_valid(cvt_out_valid), .cvt_out_data(cvt_out_data),
        .state(state), .busy(busy), .done(done), .pixels_done(pixels_done),
        .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // image memory, read data one cycle after the strobe
    logic [7:0] mem_in [0:63];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_in[mem_rd_addr[5:0]];

    // converter: average of the triple, one cycle after acceptance
    always @(posedge clk) begin
        cvt_out_valid <= 1'b0;
        if (cvt_in_valid && cvt_in_ready) begin
            cvt_out_valid <= 1'b1;
            cvt_out_data  <= 8'((int'(cvt_r) + int'(cvt_g) + int'(cvt_b)) / 3);
        end
    end

    // transaction log
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wc_q[$];
    int            first_rd = -1;
    int            done_cyc = -1;
    logic          done_prev = 1'b0;
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wa_q.push_back(mem_wr_addr);
            wd_q.push_back(mem_wr_data);
            wc_q.push_back(cyc);
            $display("[%0d] write addr=%0d data=0x%02h", cyc, mem_wr_addr, mem_wr_data);
        end
        if (mem_rd_en && first_rd < 0) first_rd = cyc;
        if (done && !done_prev && done_cyc < 0) done_cyc = cyc;
        done_prev = done;
    end

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        first_rd = -1; done_cyc = -1;
    endtask

    // start pulse; returns the cycle in which RD_R should be visible
    task automatic do_start(input logic [AW-1:0] cnt, output int c);
        @(negedge clk);
        start = 1'b1; pixel_count = cnt;
        @(negedge clk);
        start = 1'b0;
        c = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++; if ({mem_rd_en, mem_wr_en, cvt_in_valid, busy, done, cfg_error} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 000000", {mem_rd_en, mem_wr_en, cvt_in_valid, busy, done, cfg_error}); end
        n_checks++; if (pixels_done !== '0 || mem_rd_addr !== '0 || mem_wr_addr !== '0) begin
            n_fail++; $display("FAIL reset_counters: pd=%0d ra=%0d wa=%0d expected 0", pixels_done, mem_rd_addr, mem_wr_addr); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL reset_release: got %0d expected 1", state); end
        $display("test_reset: state=%0d", state);
    endtask

    task automatic test_bad_config();
        logic [AW-1:0] bad [2];
        bad[0] = 32'd0; bad[1] = 32'd40961;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b1; pixel_count = bad[i];
            @(negedge clk);
            start = 1'b0;
            n_checks++; if (cfg_error !== 1'b1) begin n_fail++; $display("FAIL bad_cfg_pulse count=%0d: got %b expected 1", bad[i], cfg_error); end
            n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL bad_cfg_state count=%0d: got %0d expected 1", bad[i], state); end
            @(negedge clk);
            n_checks++; if (cfg_error !== 1'b0) begin n_fail++; $display("FAIL bad_cfg_single count=%0d: got %b expected 0", bad[i], cfg_error); end
            $display("test_bad_config: count=%0d rejected", bad[i]);
        end
    endtask

    task automatic test_single_pixel();
        int c;
        mem_in[0] = 8'h30; mem_in[1] = 8'h60; mem_in[2] = 8'h90;
        clear_logs();
        do_start(32'd1, c);
        n_checks++; if (state !== 3'd2 || mem_rd_en !== 1'b1 || mem_rd_addr !== 32'd0) begin
            n_fail++; $display("FAIL single_first_read: state=%0d rd_en=%b addr=%0d expected 2/1/0", state, mem_rd_en, mem_rd_addr); end
        for (int i = 0; i < 50 && !done; i++) @(negedge clk);
        #1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b expected 1", done); end
        n_checks++; if (wa_q.size() != 3) begin n_fail++; $display("FAIL single_nwrites: got %0d expected 3", wa_q.size()); end
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            n_checks++; if (wa_q[i] !== OUT_BASE + AW'(i) || wd_q[i] !== 8'h60 || wc_q[i] != c + 6 + i) begin
                n_fail++; $display("FAIL single_write%0d: addr=%0d data=0x%02h cyc=%0d expected %0d/0x60/%0d",
                                   i, wa_q[i], wd_q[i], wc_q[i] - c, OUT_BASE + AW'(i), 6 + i); end
        end
        n_checks++; if (done_cyc - first_rd != 9) begin n_fail++; $display("FAIL single_latency: got %0d expected 9", done_cyc - first_rd); end
        n_checks++; if (pixels_done !== 32'd1 || state !== 3'd5 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_final: pd=%0d state=%0d busy=%b expected 1/5/0", pixels_done, state, busy); end
        $display("test_single_pixel: pixels_done=%0d", pixels_done);
    endtask

    task automatic test_backpressure();
        int c;
        logic [DW-1:0] exp_d [6];
        mem_in[0] = 8'd10; mem_in[1] = 8'd20; mem_in[2] = 8'd30;
        mem_in[3] = 8'd40; mem_in[4] = 8'd50; mem_in[5] = 8'd60;
        exp_d[0] = 8'd20; exp_d[1] = 8'd20; exp_d[2] = 8'd20;
        exp_d[3] = 8'd50; exp_d[4] = 8'd50; exp_d[5] = 8'd50;
        clear_logs();
        cvt_in_ready = 1'b0;
        do_start(32'd2, c);
        for (int i = 0; i < 20 && !cvt_in_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (cvt_in_valid !== 1'b1 || cvt_r !== 8'd10 || cvt_g !== 8'd20 || cvt_b !== 8'd30 || mem_wr_en !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: v=%b rgb=%0d,%0d,%0d wr=%b expected 1/10,20,30/0",
                                   i, cvt_in_valid, cvt_r, cvt_g, cvt_b, mem_wr_en); end
            @(negedge clk);
        end
        cvt_in_ready = 1'b1;
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        #1;
        n_checks++; if (done !== 1'b1 || pixels_done !== 32'd2) begin
            n_fail++; $display("FAIL bp_done: done=%b pd=%0d expected 1/2", done, pixels_done); end
        n_checks++; if (wa_q.size() != 6) begin n_fail++; $display("FAIL bp_nwrites: got %0d expected 6", wa_q.size()); end
        for (int i = 0; i < 6 && i < wa_q.size(); i++) begin
            n_checks++; if (wa_q[i] !== OUT_BASE + AW'(i) || wd_q[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL bp_write%0d: addr=%0d data=%0d expected %0d/%0d", i, wa_q[i], wd_q[i], OUT_BASE + AW'(i), exp_d[i]); end
        end
        $display("test_backpressure: writes=%0d", wa_q.size());
    endtask

    task automatic test_pause_resume();
        int c;
        mem_in[0] = 8'd3;  mem_in[1] = 8'd6;  mem_in[2] = 8'd9;
        mem_in[3] = 8'd12; mem_in[4] = 8'd15; mem_in[5] = 8'd18;
        mem_in[6] = 8'd90; mem_in[7] = 8'd90; mem_in[8] = 8'd90;
        clear_logs();
        do_start(32'd3, c);
        for (int i = 0; i < 30 && pixels_done != 32'd1; i++) @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 30 && state != 3'd3; i++) @(negedge clk);
        n_checks++; if (state !== 3'd3 || pixels_done !== 32'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL pause_entry: state=%0d pd=%0d busy=%b expected 3/2/1", state, pixels_done, busy); end
        pause = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (state !== 3'd3 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || cvt_in_valid !== 1'b0) begin
                n_fail++; $display("FAIL pause_idle%0d: state=%0d rd=%b wr=%b cv=%b expected 3/0/0/0",
                                   i, state, mem_rd_en, mem_wr_en, cvt_in_valid); end
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        n_checks++; if (state !== 3'd2 || mem_rd_en !== 1'b1 || mem_rd_addr !== 32'd6) begin
            n_fail++; $display("FAIL resume_read: state=%0d rd=%b addr=%0d expected 2/1/6", state, mem_rd_en, mem_rd_addr); end
        for (int i = 0; i < 30 && !done; i++) @(negedge clk);
        #1;
        n_checks++; if (done !== 1'b1 || pixels_done !== 32'd3 || wa_q.size() != 9) begin
            n_fail++; $display("FAIL pause_done: done=%b pd=%0d writes=%0d expected 1/3/9", done, pixels_done, wa_q.size()); end
        if (wa_q.size() == 9) begin
            n_checks++; if (wd_q[0] !== 8'd6 || wd_q[3] !== 8'd15 || wa_q[8] !== OUT_BASE + 32'd8 || wd_q[8] !== 8'd90) begin
                n_fail++; $display("FAIL pause_data: d0=%0d d3=%0d a8=%0d d8=%0d expected 6/15/%0d/90",
                                   wd_q[0], wd_q[3], wa_q[8], wd_q[8], OUT_BASE + 32'd8); end
        end
        $display("test_pause_resume: pixels_done=%0d", pixels_done);
    endtask

    task automatic test_abort();
        int c;
        clear_logs();
        do_start(32'd2, c);
        @(negedge clk);
        n_checks++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'd1) begin
            n_fail++; $display("FAIL abort_rdg: rd=%b addr=%0d expected 1/1", mem_rd_en, mem_rd_addr); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (state !== 3'd4 || mem_rd_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: state=%0d rd=%b busy=%b expected 4/0/0", state, mem_rd_en, busy); end
        @(negedge clk);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL abort_exit: got %0d expected 1", state); end
        repeat (10) @(negedge clk);
        n_checks++; if (wa_q.size() != 0 || pixels_done !== 32'd0) begin
            n_fail++; $display("FAIL abort_nowrite: writes=%0d pd=%0d expected 0/0", wa_q.size(), pixels_done); end
        mem_in[0] = 8'h30; mem_in[1] = 8'h60; mem_in[2] = 8'h90;
        clear_logs();
        do_start(32'd1, c);
        n_checks++; if (state !== 3'd2 || mem_rd_addr !== 32'd0) begin
            n_fail++; $display("FAIL abort_restart: state=%0d addr=%0d expected 2/0", state, mem_rd_addr); end
        for (int i = 0; i < 30 && !done; i++) @(negedge clk);
        #1;
        n_checks++; if (done !== 1'b1 || wa_q.size() != 3 || (wa_q.size() > 0 && (wa_q[0] !== OUT_BASE || wd_q[0] !== 8'h60))) begin
            n_fail++; $display("FAIL abort_rerun: done=%b writes=%0d expected 1/3 first at %0d=0x60", done, wa_q.size(), OUT_BASE); end
        $display("test_abort: rerun writes=%0d", wa_q.size());
    endtask

    task automatic test_reset_mid_run();
        int c;
        clear_logs();
        do_start(32'd1, c);
        for (int i = 0; i < 30 && !(mem_wr_en && mem_wr_addr == OUT_BASE + 32'd1); i++) @(negedge clk);
        n_checks++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== OUT_BASE + 32'd1) begin
            n_fail++; $display("FAIL rst_reach_wrg: wr=%b addr=%0d expected 1/%0d", mem_wr_en, mem_wr_addr, OUT_BASE + 32'd1); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (state !== 3'd0 || {mem_rd_en, mem_wr_en, cvt_in_valid, busy, done, cfg_error} !== 6'b0) begin
            n_fail++; $display("FAIL rst_async_ctrl: state=%0d strobes=%b expected 0/000000", state,
                               {mem_rd_en, mem_wr_en, cvt_in_valid, busy, done, cfg_error}); end
        n_checks++; if (mem_wr_addr !== '0 || mem_wr_data !== '0 || mem_rd_addr !== '0 || pixels_done !== '0 || cvt_r !== '0) begin
            n_fail++; $display("FAIL rst_async_data: wa=%0d wd=%0d ra=%0d pd=%0d r=%0d expected 0", mem_wr_addr, mem_wr_data,
                               mem_rd_addr, pixels_done, cvt_r); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_hold: got %0d expected 0", state); end
        @(negedge clk);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL rst_after: got %0d expected 1", state); end
        $display("test_reset_mid_run: state=%0d", state);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_in[i] = 8'(i);
        test_reset();
        test_bad_config();
        test_single_pixel();
        test_backpressure();
        test_pause_resume();
        test_abort();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
